// File: rtl/ex_mem_wb_regs_if.sv
// ex_mem_wb_regs_if
// Bundles the EX-stage inputs, the data-memory handshake and the
// EX/MEM + MEM/WB outputs of the ex_mem_wb_regs block.
//   master : the surrounding core (drives ex_*, mem_stall, mem_rdata)
//   slave  : the pipeline-register block (drives ex_mem_*, mem_wb_*, retired_count)
interface ex_mem_wb_regs_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // EX stage
    logic             ex_valid;
    logic             ex_flush;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_memtoreg;
    logic [XLEN-1:0]  ex_alu_result;
    logic [XLEN-1:0]  ex_store_data;
    // data memory
    logic             mem_stall;
    logic [XLEN-1:0]  mem_rdata;
    // EX/MEM
    logic [4:0]       ex_mem_rd;
    logic             ex_mem_regwrite;
    logic             ex_mem_memread;
    logic             ex_mem_memwrite;
    logic [XLEN-1:0]  ex_mem_alu_result;
    logic [XLEN-1:0]  ex_mem_store_data;
    // MEM/WB
    logic [4:0]       mem_wb_rd;
    logic             mem_wb_regwrite;
    logic [XLEN-1:0]  mem_wb_wdata;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output ex_valid, ex_flush, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alu_result, ex_store_data, mem_stall, mem_rdata,
        input  ex_mem_rd, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
               ex_mem_alu_result, ex_mem_store_data, mem_wb_rd, mem_wb_regwrite,
               mem_wb_wdata, retired_count
    );

    modport slave (
        input  ex_valid, ex_flush, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alu_result, ex_store_data, mem_stall, mem_rdata,
        output ex_mem_rd, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
               ex_mem_alu_result, ex_mem_store_data, mem_wb_rd, mem_wb_regwrite,
               mem_wb_wdata, retired_count
    );
endinterface

// File: rtl/ex_mem_wb_regs.sv
// ex_mem_wb_regs
// EX/MEM and MEM/WB pipeline registers of the five-stage RISC-V core,
// plus a retired-instruction counter.
//   clk : core clock, all state changes on the rising edge
//   rst : synchronous active-high reset, clears both stages and the counter
//   bus : ex_mem_wb_regs_if.slave -- EX inputs, data-memory stall/read data,
//         EX/MEM memory controls and forwarding values, MEM/WB writeback
//         controls and data, retired_count
// Every output comes straight from a register.
module ex_mem_wb_regs #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    ex_mem_wb_regs_if.slave bus
);

    // EX/MEM stage
    logic             em_valid_reg;
    logic [4:0]       em_rd_reg;
    logic             em_regwrite_reg;
    logic             em_memread_reg;
    logic             em_memwrite_reg;
    logic             em_memtoreg_reg;
    logic [XLEN-1:0]  em_alu_reg;
    logic [XLEN-1:0]  em_store_reg;

    // MEM/WB stage
    logic             mw_valid_reg;
    logic [4:0]       mw_rd_reg;
    logic             mw_regwrite_reg;
    logic [XLEN-1:0]  mw_wdata_reg;

    logic [CNT_W-1:0] retired_reg;

    logic             ex_take;
    logic [XLEN-1:0]  wdata_next;

    // A real, unsquashed instruction leaves EX this cycle.
    assign ex_take    = bus.ex_valid & ~bus.ex_flush;
    assign wdata_next = em_memtoreg_reg ? bus.mem_rdata : em_alu_reg;

    // EX/MEM. A stall outranks a flush: the held instruction is older than
    // whatever EX is squashing, so it must not be thrown away. Bubbles clear
    // every field, which also keeps the strobes qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            em_valid_reg    <= 1'b0;
            em_rd_reg       <= '0;
            em_regwrite_reg <= 1'b0;
            em_memread_reg  <= 1'b0;
            em_memwrite_reg <= 1'b0;
            em_memtoreg_reg <= 1'b0;
            em_alu_reg      <= '0;
            em_store_reg    <= '0;
        end else if (!bus.mem_stall) begin
            em_valid_reg    <= ex_take;
            em_rd_reg       <= ex_take ? bus.ex_rd         : 5'd0;
            em_regwrite_reg <= ex_take & bus.ex_regwrite;
            em_memread_reg  <= ex_take & bus.ex_memread;
            em_memwrite_reg <= ex_take & bus.ex_memwrite;
            em_memtoreg_reg <= ex_take & bus.ex_memtoreg;
            em_alu_reg      <= ex_take ? bus.ex_alu_result : '0;
            em_store_reg    <= ex_take ? bus.ex_store_data : '0;
        end
    end

    // MEM/WB. While memory stalls the MEM instruction has not completed, so
    // WB receives a bubble. The x0 mask is folded in here so the register
    // file sees a clean write enable.
    always_ff @(posedge clk) begin
        if (rst || bus.mem_stall) begin
            mw_valid_reg    <= 1'b0;
            mw_rd_reg       <= '0;
            mw_regwrite_reg <= 1'b0;
            mw_wdata_reg    <= '0;
        end else begin
            mw_valid_reg    <= em_valid_reg;
            mw_rd_reg       <= em_rd_reg;
            mw_regwrite_reg <= em_valid_reg & em_regwrite_reg & (em_rd_reg != 5'd0);
            mw_wdata_reg    <= wdata_next;
        end
    end

    // The instruction sitting in WB retires this cycle, stall or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (mw_valid_reg) begin
            retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    assign bus.ex_mem_rd         = em_rd_reg;
    assign bus.ex_mem_regwrite   = em_regwrite_reg;
    assign bus.ex_mem_memread    = em_memread_reg;
    assign bus.ex_mem_memwrite   = em_memwrite_reg;
    assign bus.ex_mem_alu_result = em_alu_reg;
    assign bus.ex_mem_store_data = em_store_reg;
    assign bus.mem_wb_rd         = mw_rd_reg;
    assign bus.mem_wb_regwrite   = mw_regwrite_reg;
    assign bus.mem_wb_wdata      = mw_wdata_reg;
    assign bus.retired_count     = retired_reg;

endmodule
